// File: rtl/or1200_tb_arb_pkg.sv
// or1200_tb_arb_pkg: states, grant encoding and arbitration rule for the bench Wishbone arbiter
package or1200_tb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_e;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_I    = 2'b01;
    localparam gnt_t GNT_D    = 2'b10;

    // last = 1 means the data master owned the bus most recently
    function automatic arb_state_e arbitrate(input logic c0, input logic c1, input logic last);
        return (c0 && c1) ? (last ? OWN_I : OWN_D) : c0 ? OWN_I : c1 ? OWN_D : IDLE;
    endfunction

endpackage

// File: rtl/or1200_tb_wb_watchdog.sv
// or1200_tb_wb_watchdog: saturating wait counter that pulses expire when a slave never answers
module or1200_tb_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // expire fires on the waiting cycle whose count has reached the limit; TIMEOUT 0 never fires
    always_comb begin
        expire = (TIMEOUT != 0) && active && (cnt_q == LIMIT);
        cnt_d  = (clear || expire) ? '0 : (active && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // wait counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/or1200_tb_wb_arbiter.sv
// or1200_tb_wb_arbiter: two-master round-robin Wishbone arbiter holding the grant for a whole cyc tenure
module or1200_tb_wb_arbiter
    import or1200_tb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      gnt_o
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       own_i, own_d, own_stb, resp, active, expire;

    assign own_i   = state_q == OWN_I;
    assign own_d   = state_q == OWN_D;
    assign own_stb = (own_i && m0_cyc_i && m0_stb_i) || (own_d && m1_cyc_i && m1_stb_i);
    assign resp    = s_ack_i || s_err_i || s_rty_i;
    assign active  = own_stb && !resp;

    // hold the grant while the owner keeps cyc; otherwise re-arbitrate in the same cycle
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        if (state_q == IDLE || (own_i && !m0_cyc_i) || (own_d && !m1_cyc_i)) begin
            state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_gnt_q);
            if (state_d != IDLE) last_gnt_d = state_d == OWN_D;
        end
    end

    // arbitration state; reset marks master 1 as last owner so master 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end

    or1200_tb_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (active),
        .clear  (!active),
        .expire (expire)
    );

    // forward the owner's request to the slave and route responses back to the owner only
    always_comb begin
        s_cyc_o  = own_i ? m0_cyc_i : own_d ? m1_cyc_i : 1'b0;
        s_stb_o  = (own_i ? m0_stb_i : own_d ? m1_stb_i : 1'b0) && !expire;
        s_we_o   = own_i ? m0_we_i  : own_d ? m1_we_i  : 1'b0;
        s_adr_o  = own_i ? m0_adr_i : own_d ? m1_adr_i : '0;
        s_dat_o  = own_i ? m0_dat_i : own_d ? m1_dat_i : '0;
        s_sel_o  = own_i ? m0_sel_i : own_d ? m1_sel_i : '0;
        s_cti_o  = own_i ? m0_cti_i : own_d ? m1_cti_i : '0;
        s_bte_o  = own_i ? m0_bte_i : own_d ? m1_bte_i : '0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        m0_ack_o = own_i && s_ack_i;
        m1_ack_o = own_d && s_ack_i;
        m0_err_o = own_i && (s_err_i || expire);
        m1_err_o = own_d && (s_err_i || expire);
        m0_rty_o = own_i && s_rty_i;
        m1_rty_o = own_d && s_rty_i;
        gnt_o    = own_i ? GNT_I : own_d ? GNT_D : GNT_NONE;
    end

endmodule

// File: doc/or1200_tb_wb_arbiter.md
# or1200_tb_wb_arbiter

Two-master Wishbone B3 arbiter that lets the OR1200 instruction bus (master 0) and data bus (master 1) share one single-ported unified memory slave in the simulation bench. It holds a grant for the whole `cyc` tenure, so bursts are never split. It alternates ownership round-robin on contention. A watchdog terminates any access the slave never acknowledges, so a broken memory model produces a bus error instead of a hang.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; `sel` is `DW/8`.
- `TIMEOUT`, default 255: cycles without slave response before forced `err`. A value of 0 disables the watchdog.

Ports:
- `clk`  in  1  single bench clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  instruction master control.
- `m0_adr_i`  in  AW; `m0_dat_i`  in  DW; `m0_sel_i`  in  DW/8; `m0_cti_i`  in  3; `m0_bte_i`  in  2.
- `m0_dat_o`  out  DW; `m0_ack_o`, `m0_err_o`, `m0_rty_o`  out  1 each.
- `m1_*`: same set as `m0_*`, for the data master.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each; `s_adr_o`  out  AW; `s_dat_o`  out  DW; `s_sel_o`  out  DW/8; `s_cti_o`  out  3; `s_bte_o`  out  2.
- `s_dat_i`  in  DW; `s_ack_i`, `s_err_i`, `s_rty_i`  in  1 each.
- `gnt_o`  out  2  one-hot current owner; `2'b00` when idle.

## Operation
- FSM states: `IDLE`, `OWN_I`, `OWN_D`. The state register and the `last_gnt` bit are the only arbitration state.
- Arbitration function, evaluated in `IDLE` and on release:
  - Neither `mX_cyc_i` high: next state `IDLE`.
  - One master high: grant that master.
  - Both high: grant the master that is not `last_gnt`.
  - `last_gnt` updates on every grant.
- In `OWN_x`:
  - Granted master's request signals pass combinationally to `s_*_o`.
  - `s_ack_i`, `s_err_i`, `s_rty_i` route to the granted master only.
  - The other master's ack/err/rty are held at 0.
  - Both `mX_dat_o` always equal `s_dat_i`.
- Release: the granted master's `cyc` is low at a clock edge. The arbitration function is re-evaluated in that same cycle, so handoff to a waiting master takes zero dead cycles.
- Bursts (`cti` = 001/010) need no special handling, because the grant is held while `cyc` stays high.
- `stb` low with `cyc` high keeps the grant and forwards `s_stb_o`=0.
- Watchdog:
  - Counts while granted `stb` is high and `s_ack_i|s_err_i|s_rty_i` is 0; clears otherwise.
  - When the count reaches `TIMEOUT`, the granted master receives `err`=1 for exactly one cycle.
  - In that cycle `s_stb_o` is forced to 0 and the counter clears. Ownership is unchanged.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and does not wrap.
- A slave response arriving in the timeout cycle wins; no `err` is generated.

## Timing
- Reset state:
  - State `IDLE`; `last_gnt`=1, so master 0 wins the first tie; counter 0.
  - All `s_*_o` 0; all `mX_ack_o`, `mX_err_o`, `mX_rty_o` 0; `gnt_o`=0.
- Idle outputs: with no owner, `s_cyc_o`, `s_stb_o`, `s_we_o` are 0 and address, data, `sel`, `cti`, `bte` are 0.
- Arbitration latency: `cyc`&`stb` rising in `IDLE` gives `s_cyc_o` on the next cycle (1 cycle).
- Handoff on release: 1 cycle from the owner's `cyc` falling to the new owner appearing on `s_*`.
- Slave-to-master response paths are purely combinational. Ack latency equals slave latency plus 0.
- Reset asserted mid-transfer: outputs go to reset values immediately, without waiting for `clk`. The aborted access is not completed.
- A master that drops `cyc` while another holds the grant leaves no pending request.

## Structure
- Package `or1200_tb_arb_pkg` holds:
  - `arb_state_e` (`IDLE`/`OWN_I`/`OWN_D`).
  - `gnt_t` (logic [1:0]).
  - Constants `GNT_NONE`, `GNT_I`, `GNT_D`.
- Sub-module `or1200_tb_wb_watchdog` holds the parameterised saturating counter:
  - Inputs: `clk`, `rst_n`, `active`, `clear`.
  - Output: `expire` pulse.
- The top contains the FSM and the muxing.

## Test plan
- Single master: m0 reads 0x100 and the slave acks on its 2nd cycle. Check `s_cyc_o` rises 1 cycle after `m0_cyc_i`, `m0_ack_o` pulses once, `m1_ack_o` stays 0, `gnt_o`=01.
- Tie after reset: m0 and m1 raise `cyc` in the same cycle. Check m0 is granted first. After m0 drops `cyc`, m1 is granted on the next cycle with no idle cycle between.
- Round-robin: both masters request continuously, each issuing 4 single transfers per tenure. Check grants alternate 01, 10, 01, 10.
- Burst hold: m1 runs a 4-beat incrementing burst at 0x2000 (`cti` 010, then 111) while m0 requests. Check m0 is not granted until m1 drops `cyc`, and all 4 `m1_ack_o` pulses arrive.
- Watchdog: set `TIMEOUT`=8 and have the slave never ack. Check `m0_err_o`=1 for exactly 1 cycle, 8 cycles after `stb` rises, with `s_stb_o`=0 in that cycle. Repeat with `TIMEOUT`=0 and check there is never an `err`.
- Async reset: drop `rst_n` mid-burst between clock edges. Check `s_cyc_o` and `gnt_o` go to 0 before the next `clk` edge, and the state returns to `IDLE` with master 0 winning the next tie.
